prio_scan_enc: RTL and testbench

- Parametrised, sequential successor to the team's 4-to-2 priority encoder.
- Captures an N-bit request vector and emits the index of every set bit, one per accepted output transfer, highest index first.
- Output uses a valid/ready handshake.
- Used wherever multiple simultaneous events (interrupt lines, error flags) must be serialised into an index stream for a downstream consumer.

---
 rtl/prio_scan_enc.sv | 139 +++++++++++++
 tb/tb_prio_scan_enc.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/prio_scan_enc.sv
// Sequential priority scanner: captures an N-bit request vector and emits
// every set index, highest first, over a valid/ready output handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   d          request vector, d[N-1] highest priority
//   load       capture d while in_ready=1
//   in_ready   idle and able to capture
//   a          index of current highest pending bit (0 when !valid)
//   valid      a is meaningful
//   out_ready  consumer accepts a this cycle
//   last       a is the final pending index of this vector
//   none       one-cycle pulse after an all-zero vector was loaded
//   remaining  (PRIO_SCAN_CNT_EN only) indices left incl. current one
//
// Optional feature macro: PRIO_SCAN_CNT_EN adds the remaining counter.
module prio_scan_enc #(
  parameter int N    = 8,
  parameter int IDXW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    d,
  input  logic            load,
  output logic            in_ready,
  output logic [IDXW-1:0] a,
  output logic            valid,
  input  logic            out_ready,
  output logic            last,
  output logic            none
`ifdef PRIO_SCAN_CNT_EN
  ,
  output logic [IDXW:0]   remaining
`endif
);

  typedef enum logic {
    S_IDLE,
    S_SCAN
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [N-1:0]    r_mask;
  logic [N-1:0]    w_mask_nxt;
  logic            r_none;
  logic            w_none_nxt;
  logic [IDXW-1:0] w_hi_idx;
  logic            w_one_left;
  logic            w_scan;

  // Ascending loop so the highest set bit wins.
  always_comb begin
    w_hi_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (r_mask[i]) w_hi_idx = IDXW'(i);
    end
  end

  // Exactly one bit set: clearing the lowest set bit leaves nothing.
  assign w_one_left = (r_mask != '0) &&
                      ((r_mask & (r_mask - N'(1))) == '0);

  assign w_scan = (r_state == S_SCAN);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_mask  <= '0;
      r_none  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_mask  <= w_mask_nxt;
      r_none  <= w_none_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mask_nxt  = r_mask;
    w_none_nxt  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (load) begin
          if (d != '0) begin
            w_mask_nxt  = d;
            w_state_nxt = S_SCAN;
          end else begin
            w_none_nxt = 1'b1;
          end
        end
      end
      S_SCAN: begin
        if (out_ready) begin
          w_mask_nxt = r_mask & ~(N'(1) << w_hi_idx);
          if (w_one_left) w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_mask_nxt  = '0;
      end
    endcase
  end

  assign in_ready = ~w_scan;
  assign valid    = w_scan;
  assign a        = w_scan ? w_hi_idx : '0;
  assign last     = w_scan & w_one_left;
  assign none     = r_none;

`ifdef PRIO_SCAN_CNT_EN
  localparam int CW = IDXW + 1;

  logic [CW-1:0] r_remaining;
  logic [CW-1:0] w_pop_d;

  always_comb begin
    w_pop_d = '0;
    for (int i = 0; i < N; i++) begin
      w_pop_d = w_pop_d + CW'(d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_remaining <= '0;
    end else if (!w_scan && load) begin
      r_remaining <= w_pop_d;
    end else if (w_scan && out_ready) begin
      r_remaining <= r_remaining - CW'(1);
    end
  end

  assign remaining = r_remaining;
`endif

endmodule

// File: tb/tb_prio_scan_enc.sv
// Randomised and directed bench for prio_scan_enc at N=8 and N=5,
// checked against a queue-based model of the index stream.
module tb_prio_scan_enc;

  typedef int iq_t[$];

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] d = '0;

  logic       ir8, v8, l8, n8;
  logic [2:0] a8;
  logic       ir5, v5, l5, n5;
  logic [2:0] a5;
`ifdef PRIO_SCAN_CNT_EN
  logic [3:0] rem8, rem5;
`endif

  int n_chk = 0;
  int n_err = 0;

  iq_t q8, q5;
  bit  none8 = 0;
  bit  none5 = 0;

  always #5 clk = ~clk;

  prio_scan_enc #(.N(8)) u8 (
    .clk(clk), .rst(rst), .d(d), .load(load),
    .in_ready(ir8), .a(a8), .valid(v8),
    .out_ready(out_ready), .last(l8), .none(n8)
`ifdef PRIO_SCAN_CNT_EN
    , .remaining(rem8)
`endif
  );

  prio_scan_enc #(.N(5)) u5 (
    .clk(clk), .rst(rst), .d(d[4:0]), .load(load),
    .in_ready(ir5), .a(a5), .valid(v5),
    .out_ready(out_ready), .last(l5), .none(n5)
`ifdef PRIO_SCAN_CNT_EN
    , .remaining(rem5)
`endif
  );

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d expected %0d",
               tag, $time, obs, exp);
    end
  endtask

  // Indices of set bits, highest first.
  function automatic iq_t idx_list(input logic [7:0] v, input int n);
    iq_t q;
    for (int i = n - 1; i >= 0; i--) if (v[i]) q.push_back(i);
    return q;
  endfunction

  task automatic model_update();
    logic [7:0] d5;
    d5 = {3'b000, d[4:0]};
    if (rst) begin
      q8 = {};
      q5 = {};
      none8 = 0;
      none5 = 0;
    end else begin
      if (q8.size() == 0) begin
        none8 = load && (d == 8'h00);
        if (load && d != 8'h00) q8 = idx_list(d, 8);
      end else begin
        none8 = 0;
        if (out_ready) void'(q8.pop_front());
      end
      if (q5.size() == 0) begin
        none5 = load && (d5 == 8'h00);
        if (load && d5 != 8'h00) q5 = idx_list(d5, 5);
      end else begin
        none5 = 0;
        if (out_ready) void'(q5.pop_front());
      end
    end
  endtask

  task automatic check_all();
    int s8, s5;
    s8 = q8.size();
    s5 = q5.size();
    check("in_ready8", ir8, s8 == 0);
    check("valid8", v8, s8 != 0);
    check("a8", a8, s8 != 0 ? q8[0] : 0);
    check("last8", l8, s8 == 1);
    check("none8", n8, none8);
    check("in_ready5", ir5, s5 == 0);
    check("valid5", v5, s5 != 0);
    check("a5", a5, s5 != 0 ? q5[0] : 0);
    check("last5", l5, s5 == 1);
    check("none5", n5, none5);
`ifdef PRIO_SCAN_CNT_EN
    check("rem8", rem8, s8);
    check("rem5", rem5, s5);
`endif
  endtask

  // Drive at negedge, advance model at posedge, check at next negedge.
  task automatic step(input logic r, input logic ld,
                      input logic [7:0] dv, input logic orr);
    rst       = r;
    load      = ld;
    d         = dv;
    out_ready = orr;
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    @(negedge clk);
    step(1, 0, 8'h00, 0);
    step(1, 1, 8'hFF, 1);
    // 0x81 with consumer always ready
    step(0, 1, 8'h81, 1);
    repeat (3) step(0, 0, 8'h00, 1);
    // all-zero load
    step(0, 1, 8'h00, 1);
    repeat (2) step(0, 0, 8'h00, 1);
    // back-pressure hold
    step(0, 1, 8'h64, 0);
    repeat (3) step(0, 0, 8'h00, 0);
    repeat (4) step(0, 0, 8'h00, 1);
    // load ignored during scan
    step(0, 1, 8'h03, 0);
    step(0, 1, 8'hFF, 1);
    step(0, 1, 8'hFF, 1);
    repeat (2) step(0, 0, 8'h00, 1);
    // reset mid-scan, then single-bit vector
    step(0, 1, 8'hFF, 0);
    repeat (2) step(0, 0, 8'h00, 1);
    step(1, 0, 8'h00, 1);
    step(0, 1, 8'h10, 0);
    repeat (2) step(0, 0, 8'h00, 1);
    // full low vector: N=5 walks 4..0
    step(0, 1, 8'h1F, 1);
    repeat (6) step(0, 0, 8'h00, 1);
    // random traffic
    for (int i = 0; i < 600; i++) begin
      logic [7:0] dv;
      dv = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      step($urandom_range(0, 49) == 0,
           $urandom_range(0, 2) == 0,
           dv,
           $urandom_range(0, 9) < 7);
    end
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
